// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR MAC control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature: FIR_COEF_RELOAD_EN adds the RELOAD state to the FSM enum.
package fir_ctrl_pkg;

    localparam int FIR_NTAPS_DEF   = 32;   // default filter length
    localparam int FIR_MAC_LAT_DEF = 3;    // default MAC pipeline depth
    localparam int SAMPLE_W        = 17;   // datapath sample width

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
`ifdef FIR_COEF_RELOAD_EN
        ,
        ST_RELOAD = 3'd5
`endif
    } fir_state_t;

endpackage

// File: rtl/fir_ring_addr.sv
// Modulo-NTAPS up/down address counter (NTAPS a power of two, so wrap is free).
// Latency: load/step take effect on the next clock edge.
// Backpressure: none; load has priority over en.
// Ports: clk, reset (sync, active-high), load/load_val, en (step), down (direction), addr.
module fir_ring_addr #(
    parameter int  NTAPS  = 32,
    localparam int ADDR_W = $clog2(NTAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  logic              down,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (en) begin
            addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one NTAPS-tap FIR pass per accepted sample: delay-line write, NTAPS MACs, drain, result strobe.
// Latency: accept in cycle t -> y_valid in t+NTAPS+MAC_LAT+1, x_ready again in t+NTAPS+MAC_LAT+2.
// Backpressure: x_ready only in IDLE; x_valid while not ready is dropped and sets sticky overrun.
// Ports: clk_100MHz, reset (sync, active-high); x_valid/x_ready; samp_we/samp_zero/samp_waddr,
//        samp_raddr, coef_raddr to the RAMs; mac_clr/mac_en to the MAC; y_valid, overrun, busy.
// Optional feature: FIR_COEF_RELOAD_EN adds coef_load/coef_in_valid/coef_we/coef_waddr/coef_busy.
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int  NTAPS   = FIR_NTAPS_DEF,
    parameter int  MAC_LAT = FIR_MAC_LAT_DEF,
    localparam int ADDR_W  = $clog2(NTAPS)
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              x_valid,
    output logic              x_ready,
    output logic              samp_we,
    output logic              samp_zero,
    output logic [ADDR_W-1:0] samp_waddr,
    output logic [ADDR_W-1:0] samp_raddr,
    output logic [ADDR_W-1:0] coef_raddr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              y_valid,
    output logic              overrun,
`ifdef FIR_COEF_RELOAD_EN
    input  logic              coef_load,
    input  logic              coef_in_valid,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_waddr,
    output logic              coef_busy,
`endif
    output logic              busy
);

    // One counter serves CLEAR addresses, RUN tap index and DRAIN length, so it
    // must hold both NTAPS and MAC_LAT (up to 8).
    localparam int CNT_W = (ADDR_W + 1 > 4) ? ADDR_W + 1 : 4;
    localparam logic [CNT_W-1:0] CNT_NTAPS = CNT_W'(NTAPS);
    localparam logic [CNT_W-1:0] CNT_MACLAT = CNT_W'(MAC_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fir_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wptr;
    logic              accept, wptr_step, rd_load, rd_step;
    logic              samp_we_d, samp_zero_d, mac_clr_d, mac_en_d, y_valid_d, overrun_d;
    logic [ADDR_W-1:0] samp_waddr_d, coef_raddr_d;

    assign x_ready = (state_q == ST_IDLE);

`ifdef FIR_COEF_RELOAD_EN
    assign accept     = x_ready && x_valid && !coef_load;
    assign coef_we    = (state_q == ST_RELOAD) && coef_in_valid;
    assign coef_waddr = cnt_q[ADDR_W-1:0];
    assign coef_busy  = (state_q == ST_RELOAD);
`else
    assign accept     = x_ready && x_valid;
`endif

    // Write pointer: advances once per accepted sample.
    fir_ring_addr #(.NTAPS(NTAPS)) u_wptr (
        .clk      (clk_100MHz),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .en       (wptr_step),
        .down     (1'b0),
        .addr     (wptr)
    );

    // Read address: loaded with the just-written slot (w) on accept, then walks
    // backwards through history, giving (w-k) mod NTAPS. Its register doubles as
    // the latched w, so no separate copy is kept.
    fir_ring_addr #(.NTAPS(NTAPS)) u_raddr (
        .clk      (clk_100MHz),
        .reset    (reset),
        .load     (rd_load),
        .load_val (wptr),
        .en       (rd_step),
        .down     (1'b1),
        .addr     (samp_raddr)
    );

    // Registered outputs are loaded with the values belonging to the state being
    // entered, so they line up cycle-for-cycle with state_q.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        samp_we_d    = 1'b0;
        samp_zero_d  = 1'b0;
        samp_waddr_d = samp_waddr;
        coef_raddr_d = coef_raddr;
        mac_clr_d    = 1'b0;
        mac_en_d     = 1'b0;
        y_valid_d    = 1'b0;
        overrun_d    = overrun | (x_valid && !x_ready && (state_q != ST_CLEAR));
        wptr_step    = 1'b0;
        rd_load      = 1'b0;
        rd_step      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_NTAPS) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    samp_we_d    = 1'b1;
                    samp_zero_d  = 1'b1;
                    samp_waddr_d = cnt_q[ADDR_W-1:0];
                    cnt_d        = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                // The tap-0 read hits the slot being written this same cycle;
                // the delay-line RAM must be write-first for that address.
                if (accept) begin
                    samp_we_d    = 1'b1;
                    samp_waddr_d = wptr;
                    wptr_step    = 1'b1;
                    rd_load      = 1'b1;
                    coef_raddr_d = '0;
                    mac_en_d     = 1'b1;
                    mac_clr_d    = 1'b1;
                    cnt_d        = CNT_ONE;
                    state_d      = ST_RUN;
                end
`ifdef FIR_COEF_RELOAD_EN
                if (coef_load) begin
                    cnt_d   = '0;
                    state_d = ST_RELOAD;
                end
`endif
            end
            ST_RUN: begin
                // cnt_q is the next tap index to issue; tap 0 went out on accept.
                if (cnt_q == CNT_NTAPS) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_DRAIN;
                end else begin
                    mac_en_d     = 1'b1;
                    coef_raddr_d = cnt_q[ADDR_W-1:0];
                    rd_step      = 1'b1;
                    cnt_d        = cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_MACLAT) begin
                    y_valid_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
`ifdef FIR_COEF_RELOAD_EN
            ST_RELOAD: begin
                if (coef_in_valid) begin
                    if (cnt_q == CNT_NTAPS - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            samp_we    <= 1'b0;
            samp_zero  <= 1'b0;
            samp_waddr <= '0;
            coef_raddr <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            y_valid    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_we    <= samp_we_d;
            samp_zero  <= samp_zero_d;
            samp_waddr <= samp_waddr_d;
            coef_raddr <= coef_raddr_d;
            mac_clr    <= mac_clr_d;
            mac_en     <= mac_en_d;
            y_valid    <= y_valid_d;
            overrun    <= overrun_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with NTAPS=4, MAC_LAT=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Define FIR_COEF_RELOAD_EN to also exercise the coefficient reload path.
module tb_fir_mac_sequencer;

    localparam int NT = 4;
    localparam int ML = 2;
    localparam int AW = 2;

    logic          clk_100MHz = 1'b0;
    logic          reset;
    logic          x_valid;
    logic          x_ready;
    logic          samp_we, samp_zero;
    logic [AW-1:0] samp_waddr, samp_raddr, coef_raddr;
    logic          mac_clr, mac_en, y_valid, overrun, busy;
`ifdef FIR_COEF_RELOAD_EN
    logic          coef_load, coef_in_valid, coef_we, coef_busy;
    logic [AW-1:0] coef_waddr;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_y = -1;

    fir_mac_sequencer #(.NTAPS(NT), .MAC_LAT(ML)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .samp_we    (samp_we),
        .samp_zero  (samp_zero),
        .samp_waddr (samp_waddr),
        .samp_raddr (samp_raddr),
        .coef_raddr (coef_raddr),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .y_valid    (y_valid),
        .overrun    (overrun),
`ifdef FIR_COEF_RELOAD_EN
        .coef_load     (coef_load),
        .coef_in_valid (coef_in_valid),
        .coef_we       (coef_we),
        .coef_waddr    (coef_waddr),
        .coef_busy     (coef_busy),
`endif
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        cyc++;
    endtask

    // Accept one sample expected to land at slot w, then follow it to the
    // point where x_ready returns. hold_x keeps x_valid high through RUN.
    task automatic do_sample(input int w, input bit hold_x);
        chk("pre_x_ready", 32'(x_ready), 1);
        x_valid = 1'b1;
        tick();
        if (!hold_x) x_valid = 1'b0;
        for (int k = 0; k < NT; k++) begin
            chk("raddr", 32'(samp_raddr), (w - k) & (NT - 1));
            chk("coef_raddr", 32'(coef_raddr), k);
            chk("mac_en", 32'(mac_en), 1);
            chk("mac_clr", 32'(mac_clr), 32'(k == 0));
            chk("samp_we", 32'(samp_we), 32'(k == 0));
            chk("run_x_ready", 32'(x_ready), 0);
            if (k == 0) chk("samp_waddr", 32'(samp_waddr), w);
            if (hold_x) chk("overrun_run", 32'(overrun), 32'(k != 0));
            tick();
        end
        x_valid = 1'b0;
        for (int d = 0; d < ML; d++) begin
            chk("drain_mac_en", 32'(mac_en), 0);
            chk("drain_y_valid", 32'(y_valid), 0);
            tick();
        end
        chk("y_valid", 32'(y_valid), 1);
        chk("done_x_ready", 32'(x_ready), 0);
        if (last_y >= 0) chk("y_gap", 32'(cyc - last_y), NT + ML + 2);
        last_y = cyc;
        tick();
        chk("idle_x_ready", 32'(x_ready), 1);
        chk("idle_y_valid", 32'(y_valid), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic clear_sweep();
        for (int i = 0; i < NT; i++) begin
            tick();
            chk("clr_we", 32'(samp_we), 1);
            chk("clr_zero", 32'(samp_zero), 1);
            chk("clr_waddr", 32'(samp_waddr), i);
            chk("clr_x_ready", 32'(x_ready), 0);
            chk("clr_y_valid", 32'(y_valid), 0);
        end
        tick();
        chk("post_clr_x_ready", 32'(x_ready), 1);
        chk("post_clr_we", 32'(samp_we), 0);
    endtask

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
`ifdef FIR_COEF_RELOAD_EN
        coef_load     = 1'b0;
        coef_in_valid = 1'b0;
`endif
        tick(); tick(); tick();
        chk("rst_samp_we", 32'(samp_we), 0);
        chk("rst_x_ready", 32'(x_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_mac_en", 32'(mac_en), 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        reset = 1'b0;
        clear_sweep();
        chk("post_clr_overrun", 32'(overrun), 0);

        // Five back-to-back samples: slots 0,1,2,3 then wrap to 0.
        do_sample(0, 1'b0);
        do_sample(1, 1'b0);
        do_sample(2, 1'b0);
        do_sample(3, 1'b0);
        do_sample(0, 1'b0);
        chk("no_overrun", 32'(overrun), 0);

        // x_valid held through RUN: only the first cycle accepts.
        do_sample(1, 1'b1);
        chk("overrun_sticky", 32'(overrun), 1);
        tick();
        chk("overrun_sticky2", 32'(overrun), 1);

        // Reset in the third RUN cycle discards the result.
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        tick(); tick();
        chk("mid_run_mac_en", 32'(mac_en), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_mac_en", 32'(mac_en), 0);
        chk("mrst_overrun", 32'(overrun), 0);
        chk("mrst_raddr", 32'(samp_raddr), 0);
        chk("mrst_y_valid", 32'(y_valid), 0);
        clear_sweep();
        last_y = -1;
        do_sample(0, 1'b0);

`ifdef FIR_COEF_RELOAD_EN
        coef_load = 1'b1;
        x_valid   = 1'b1;
        tick();
        coef_load = 1'b0;
        x_valid   = 1'b0;
        chk("rl_coef_busy", 32'(coef_busy), 1);
        chk("rl_x_ready", 32'(x_ready), 0);
        chk("rl_samp_we", 32'(samp_we), 0);
        chk("rl_busy", 32'(busy), 1);
        for (int i = 0; i < NT; i++) begin
            coef_in_valid = 1'b1;
            #1;
            chk("rl_coef_we", 32'(coef_we), 1);
            chk("rl_coef_waddr", 32'(coef_waddr), i);
            tick();
        end
        coef_in_valid = 1'b0;
        chk("rl_done_x_ready", 32'(x_ready), 1);
        chk("rl_done_coef_busy", 32'(coef_busy), 0);
        chk("rl_overrun", 32'(overrun), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter NTAPS, default 32: filter length; power of two, 4..256.
REQ-002 Parameter MAC_LAT, default 3: cycles from mac_en to a settled MAC accumulator, 1..8.
REQ-003 Derived constant ADDR_W = clog2(NTAPS).
REQ-004 clk_100MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 x_valid  in  1  a 17-bit sample is on the datapath x bus.
REQ-007 x_ready  out  1  sequencer will accept a sample this cycle.
REQ-008 samp_we  out  1  write x into the sample delay-line RAM at samp_waddr.
REQ-009 samp_zero  out  1  write zero, not x (clear sweep only).
REQ-010 samp_waddr  out  ADDR_W  delay-line write address.
REQ-011 samp_raddr  out  ADDR_W  delay-line read address.
REQ-012 coef_raddr  out  ADDR_W  coefficient read address.
REQ-013 mac_clr  out  1  load the product into the accumulator instead of adding it.
REQ-014 mac_en  out  1  the MAC consumes the current read pair.
REQ-015 y_valid  out  1  one-cycle strobe: the datapath y output is final.
REQ-016 overrun  out  1  sticky flag: x_valid was high while x_ready was low outside reset/clear.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: CLEAR, IDLE, RUN, DRAIN, DONE, and RELOAD (macro-gated).
REQ-019 CLEAR: NTAPS cycles with samp_we=samp_zero=1 and samp_waddr=0..NTAPS-1, then go to IDLE.
REQ-020 IDLE: x_ready=1; a cycle with x_valid && x_ready is an accept.
REQ-021 On accept: samp_we=1, samp_waddr=wptr; w=wptr is latched; wptr increments mod NTAPS; next state RUN.
REQ-022 RUN lasts NTAPS cycles, k=0..NTAPS-1.
- samp_raddr=(w-k) mod NTAPS, coef_raddr=k, mac_en=1.
- mac_clr=1 only when k=0.
REQ-023 DRAIN lasts MAC_LAT cycles with mac_en=0; then DONE.
REQ-024 DONE lasts one cycle: y_valid=1, then IDLE.
REQ-025 Timing from an accept in cycle t:
- y_valid in cycle t+NTAPS+MAC_LAT+1.
- x_ready again in cycle t+NTAPS+MAC_LAT+2.
REQ-026 x_valid outside IDLE is not accepted and sets overrun; overrun clears only on reset.
REQ-027 Write pointer wraps from NTAPS-1 to 0; read addresses wrap modulo NTAPS.
REQ-028 mac_en, mac_clr, samp_we and y_valid are registered outputs, low in any state not listed above.

Reset
REQ-029 reset asserted in any state, mid-operation included, forces the following on the next edge:
- state=CLEAR, wptr=0, overrun=0.
- All outputs 0; any in-flight result is discarded with no y_valid.
REQ-030 After reset deasserts, CLEAR runs in full before the first x_ready.

Configuration
REQ-031 FIR_COEF_RELOAD_EN defined adds these ports:
- coef_load  in  1  reload request.
- coef_in_valid  in  1  a coefficient word is presented.
- coef_we  out  1  write strobe to the coefficient RAM.
- coef_waddr  out  ADDR_W  coefficient write address.
- coef_busy  out  1  reload in progress.
REQ-032 With the macro defined:
- coef_load in IDLE enters RELOAD, and takes priority over a simultaneous x_valid.
- RELOAD: x_ready=0; each coef_in_valid cycle gives coef_we=1 at coef_waddr 0,1,..; exit to IDLE after the NTAPS-th write.
REQ-033 Macro undefined: reload ports and the RELOAD state are absent; coefficients are a fixed ROM.

Structure
REQ-034 Package fir_ctrl_pkg holds:
- the FSM state enum;
- default NTAPS and MAC_LAT;
- the sample width constant, 17.
REQ-035 Sub-module fir_ring_addr: a modulo-NTAPS up/down address counter, instantiated for the write pointer and the read address.

Verification
REQ-036 In all scenarios below, NTAPS=4 and MAC_LAT=2.
REQ-037 Reset release: samp_we=samp_zero=1 on waddr 0,1,2,3, then x_ready=1 in the 5th cycle.
REQ-038 Single accept at t=0 with wptr=0:
- raddr 0,3,2,1 and coef_raddr 0,1,2,3 in cycles 1-4;
- mac_clr only in cycle 1;
- y_valid in cycle 7, x_ready in cycle 8.
REQ-039 Five back-to-back samples: write addresses 0,1,2,3,0; 5th RUN raddr sequence 0,3,2,1; five y_valid strobes, 8 cycles apart.
REQ-040 x_valid held high during RUN: not accepted, overrun=1 and it stays set.
REQ-041 Reset asserted in cycle 3 of RUN: no y_valid; CLEAR restarts; wptr=0.
REQ-042 With FIR_COEF_RELOAD_EN: coef_load and x_valid together in IDLE gives RELOAD; 4 coef_in_valid cycles give waddr 0-3, then IDLE with x_ready=1.
